potential_adder: RTL
====================

POTENTIAL_ADDER -- requirements
Module: potential_adder

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 ts_start  in  1  one-cycle pulse opening a timestep; honoured only in IDLE.
REQ-004 decayed_potential  in  32  FP32 membrane potential from the decay stage; sampled on accepted ts_start.
REQ-005 weight_valid  in  1  upstream presents a synaptic weight beat.
REQ-006 weight  in  32  FP32 synaptic weight (signed).
REQ-007 weight_last  in  1  marks final beat of the timestep; qualified by weight_valid.
REQ-008 weight_ready  out  1  block accepts a beat; beat transfers when weight_valid and weight_ready are both high.
REQ-009 new_potential  out  32  FP32 accumulated potential, registered, held until next timestep result.
REQ-010 done  out  1  one-cycle pulse: new_potential valid.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 beat_count  out  8  weights accepted in current/last timestep, saturating.
REQ-013 fp_exception  out  1  sticky per timestep: adder raised Exception on an accepted beat.

Function
REQ-014 FSM states IDLE, ACCUM, DONE; only one state active per cycle.
REQ-015 IDLE: weight_ready=0; ts_start=1 -> acc<=decayed_potential, beat_count<=0, fp_exception<=0, next ACCUM.
REQ-016 ACCUM: weight_ready=1; each transfer -> acc<=acc+weight (one beat per cycle, no bubbles).
REQ-017 Transfer with weight_last=1 -> new_potential<=acc+weight on same edge, next DONE.
REQ-018 DONE: done=1 for exactly that cycle, weight_ready=0, next IDLE unconditionally.
REQ-019 Latency: done high the cycle after the last-beat transfer edge; ts_start-to-first-ready = 1 cycle.
REQ-020 beat_count increments on every transfer, saturates at 255, never wraps.
REQ-021 Adder Exception on a transfer -> acc unchanged for that beat (result discarded), fp_exception<=1, beat still counted.
REQ-022 Exception on last beat -> new_potential<=acc (pre-beat value), done still pulses.
REQ-023 ts_start in ACCUM or DONE ignored; no state or output change.
REQ-024 weight_last without weight_valid ignored.
REQ-025 Zero-beat timestep: upstream sends a single +0.0 beat with weight_last; result equals decayed_potential.
REQ-026 No new_potential change outside REQ-017/REQ-022 edges.

Reset
REQ-027 rst_n low -> immediately: state IDLE, acc=0, new_potential=0x00000000, done=0, busy=0, weight_ready=0, beat_count=0, fp_exception=0.
REQ-028 Reset mid-ACCUM discards partial sum; first post-reset action requires ts_start.
REQ-029 Release of rst_n synchronous to CLK at integration; block makes no internal synchronisation.

Structure
REQ-030 Shared package snn_fp_pkg holds FP32 width constant, FP_ZERO (0x00000000), FSM state encoding, beat_count width/saturation limit.
REQ-031 One sub-module: existing combinational FP32 adder Addition_Subtraction (operation bit tied 0 = add), single instance, acc and weight as operands.
REQ-032 Adder result not registered internally; acc register is the only pipeline stage.

Verification
REQ-033 decayed 1.0 (0x3F800000); weights 2.0 (0x40000000), 0.5 (0x3F000000, last) back-to-back -> done 1 cycle after last, new_potential 0x40600000, beat_count 2.
REQ-034 decayed 1.0; single weight -1.5 (0xBFC00000, last) -> new_potential 0xBF000000, fp_exception 0.
REQ-035 300 consecutive +0.0 beats, last on 300th -> beat_count 255, new_potential equals decayed value, weight_valid gaps cause no extra beats.
REQ-036 ts_start pulsed mid-ACCUM with decayed 5.0 -> ignored; sum continues from original base.
REQ-037 rst_n asserted after 2 of 4 beats -> all outputs at reset values same cycle; new timestep after release yields result from fresh base only.
REQ-038 Beat forcing adder Exception (e.g. 0x7F800000 operand) -> fp_exception 1, acc unchanged, done still pulses.

Source files
------------

// File: rtl/snn_fp_pkg.sv
// Shared FP32 constants, FSM encoding and beat-counter helpers for the
// spiking-neuron potential accumulation path.
package snn_fp_pkg;

  localparam int FP_WIDTH = 32;
  localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;

  localparam int BEAT_W = 8;
  localparam logic [BEAT_W-1:0] BEAT_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Saturating increment so long timesteps pin at BEAT_MAX instead of wrapping.
  function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] count);
    return (count == BEAT_MAX) ? count : count + 1'b1;
  endfunction

endpackage

// File: rtl/potential_adder_if.sv
// Timestep control, weight stream handshake and result bundle of the potential adder.
interface potential_adder_if;
  import snn_fp_pkg::*;

  logic                ts_start;
  logic [FP_WIDTH-1:0] decayed_potential;
  logic                weight_valid;
  logic [FP_WIDTH-1:0] weight;
  logic                weight_last;
  logic                weight_ready;
  logic [FP_WIDTH-1:0] new_potential;
  logic                done;
  logic                busy;
  logic [BEAT_W-1:0]   beat_count;
  logic                fp_exception;

  modport master (
    output ts_start, decayed_potential, weight_valid, weight, weight_last,
    input  weight_ready, new_potential, done, busy, beat_count, fp_exception
  );

  modport slave (
    input  ts_start, decayed_potential, weight_valid, weight, weight_last,
    output weight_ready, new_potential, done, busy, beat_count, fp_exception
  );

endinterface

// File: rtl/potential_adder_fpadd.sv
// Combinational FP32 adder/subtractor, round-to-nearest-even, subnormals flushed to zero.
// Exception flags any operand carrying an all-ones exponent (Inf/NaN).
module Addition_Subtraction
  import snn_fp_pkg::*;
(
  input  logic [FP_WIDTH-1:0] a_operand,
  input  logic [FP_WIDTH-1:0] b_operand,
  input  logic                AddBar_Sub,
  output logic                Exception,
  output logic [FP_WIDTH-1:0] result
);

  logic [31:0]       b_eff, op_a, op_b;
  logic [23:0]       man_a, man_b;
  logic [7:0]        exp_diff;
  logic [26:0]       al_a, al_full, al_b;
  logic [27:0]       sum;
  logic [26:0]       norm;
  logic [4:0]        lz;
  logic signed [9:0] exp_r;
  logic              round_up;
  logic [24:0]       rounded;
  logic [22:0]       frac;

  // Larger magnitude goes to op_a so alignment only ever shifts op_b right.
  always_comb begin
    b_eff = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    if (b_eff[30:0] > a_operand[30:0]) begin
      op_a = b_eff;
      op_b = a_operand;
    end else begin
      op_a = a_operand;
      op_b = b_eff;
    end
    man_a    = (op_a[30:23] != 8'd0) ? {1'b1, op_a[22:0]} : 24'd0;
    man_b    = (op_b[30:23] != 8'd0) ? {1'b1, op_b[22:0]} : 24'd0;
    exp_diff = op_a[30:23] - op_b[30:23];
    al_a     = {man_a, 3'b000};
    al_full  = {man_b, 3'b000};
    if (exp_diff >= 8'd27)
      al_b = {26'd0, |man_b};
    else
      al_b = (al_full >> exp_diff) | {26'd0, |(al_full & ~(27'h7FF_FFFF << exp_diff))};

    sum = (op_a[31] == op_b[31]) ? ({1'b0, al_a} + {1'b0, al_b})
                                 : ({1'b0, al_a} - {1'b0, al_b});

    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    exp_r = {2'b00, op_a[30:23]};
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_r = exp_r + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_r = exp_r - $signed({5'd0, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
    frac     = rounded[22:0];
    if (rounded[24]) begin
      exp_r = exp_r + 10'sd1;
      frac  = rounded[23:1];
    end

    Exception = (&a_operand[30:23]) | (&b_operand[30:23]);
    if (sum == 28'd0)
      result = FP_ZERO;
    else if (exp_r >= 10'sd255)
      result = {op_a[31], 8'hFF, 23'd0};
    else if (exp_r <= 10'sd0)
      result = {op_a[31], 31'd0};
    else
      result = {op_a[31], exp_r[7:0], frac};
  end

endmodule

// File: rtl/potential_adder.sv
// Accumulates a timestep's stream of FP32 synaptic weights onto the decayed
// membrane potential; the acc register is the only pipeline stage.
module potential_adder
  import snn_fp_pkg::*;
(
  input  logic            CLK,
  input  logic            rst_n,
  potential_adder_if.slave bus
);

  state_t              state, state_next;
  logic [FP_WIDTH-1:0] acc, new_potential_r, add_result;
  logic [BEAT_W-1:0]   beat_count_r;
  logic                fp_exception_r, add_exception;
  logic                transfer, weight_ready_c, busy_c, done_c;

  Addition_Subtraction u_fpadd (
    .a_operand  (acc),
    .b_operand  (bus.weight),
    .AddBar_Sub (1'b0),
    .Exception  (add_exception),
    .result     (add_result)
  );

  assign transfer = weight_ready_c & bus.weight_valid;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.ts_start) state_next = ST_ACCUM;
      ST_ACCUM: if (transfer && bus.weight_last) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    weight_ready_c = 1'b0;
    busy_c         = 1'b0;
    done_c         = 1'b0;
    case (state)
      ST_ACCUM: begin
        weight_ready_c = 1'b1;
        busy_c         = 1'b1;
      end
      ST_DONE: begin
        done_c = 1'b1;
        busy_c = 1'b1;
      end
      default: ;
    endcase
  end

  // An excepting beat is still counted, but its sum is dropped and acc keeps the pre-beat value.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      acc             <= FP_ZERO;
      new_potential_r <= FP_ZERO;
      beat_count_r    <= '0;
      fp_exception_r  <= 1'b0;
    end else if (state == ST_IDLE && bus.ts_start) begin
      acc            <= bus.decayed_potential;
      beat_count_r   <= '0;
      fp_exception_r <= 1'b0;
    end else if (transfer) begin
      beat_count_r <= sat_inc(beat_count_r);
      if (add_exception) fp_exception_r <= 1'b1;
      else               acc            <= add_result;
      if (bus.weight_last) new_potential_r <= add_exception ? acc : add_result;
    end
  end

  assign bus.weight_ready  = weight_ready_c;
  assign bus.busy          = busy_c;
  assign bus.done          = done_c;
  assign bus.new_potential = new_potential_r;
  assign bus.beat_count    = beat_count_r;
  assign bus.fp_exception  = fp_exception_r;

endmodule
